// File: rtl/pipe_hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// hazard_pkg
// Definitions shared by the pipeline hazard controller and its users:
//   - state_e           : sequencer state encoding (RUN / MEM_WAIT / ERROR)
//   - MEMWB_BUBBLE_CTRL : control word loaded into MEM/WB when mem_wb_bubble=1
//   - REG_ZERO          : index of the hard-wired $zero register
// ---------------------------------------------------------------------------
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_e;

  localparam logic [2:0] MEMWB_BUBBLE_CTRL = 3'b001;
  localparam logic [4:0] REG_ZERO          = 5'd0;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl_if
// Bundles the signals between the 5-stage pipeline datapath and the hazard
// controller.
//   Datapath -> controller : id_rs, id_rt, ex_memread, ex_rt, branch_taken,
//                            mem_req, mem_ready
//   Controller -> datapath : pc_en, if_id_en, if_id_flush, id_ex_en,
//                            id_ex_flush, ex_mem_en, mem_wb_bubble, mem_err,
//                            stall_cnt, flush_cnt
// master = datapath side, slave = controller side.
// ---------------------------------------------------------------------------
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 16
);

  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             ex_memread;
  logic [4:0]       ex_rt;
  logic             branch_taken;
  logic             mem_req;
  logic             mem_ready;

  logic             pc_en;
  logic             if_id_en;
  logic             if_id_flush;
  logic             id_ex_en;
  logic             id_ex_flush;
  logic             ex_mem_en;
  logic             mem_wb_bubble;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_rs, id_rt, ex_memread, ex_rt, branch_taken, mem_req, mem_ready,
    input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en,
           mem_wb_bubble, mem_err, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs, id_rt, ex_memread, ex_rt, branch_taken, mem_req, mem_ready,
    output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en,
           mem_wb_bubble, mem_err, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// CNT_W-bit up counter that sticks at all-ones instead of wrapping.
// Ports:
//   clk    : clock, counts on posedge
//   clr_i  : asynchronous active-high clear
//   inc_i  : count enable for this cycle
//   cnt_o  : current count
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge clr_i) begin
    if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
// Stall/flush sequencer for the 5-stage MIPS pipeline. Produces the per-stage
// load enables and flush strobes for PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
// Events handled, highest priority first:
//   ERROR (memory timeout) > memory stall > taken branch > load-use > normal
// Ports:
//   clk   : pipeline clock
//   reset : asynchronous active-high reset
//   bus   : pipe_hazard_ctrl_if slave modport (hazard inputs, stage strobes,
//           sticky mem_err, saturating stall/flush counters)
// Strobes are combinational from state and inputs; state, wait counter,
// mem_err and performance counters update on posedge clk.
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               reset,
  pipe_hazard_ctrl_if.slave  bus
);

  // Wide enough to hold MEM_TIMEOUT itself.
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q,  wait_d;
  logic               err_q,   err_d;

  logic mstall;
  logic load_use;
  logic branch_fire;

  logic pc_en;
  logic if_id_en;
  logic if_id_flush;
  logic id_ex_en;
  logic id_ex_flush;
  logic ex_mem_en;
  logic mem_wb_bubble;

  // Memory stall: a new un-ready access in RUN, or any un-ready cycle while
  // already waiting. The releasing cycle (mem_ready=1) is never stalled.
  assign mstall = ((state_q == RUN)      &&  bus.mem_req && !bus.mem_ready) ||
                  ((state_q == MEM_WAIT) && !bus.mem_ready);

  // Writes to $zero are discarded, so a load to r0 cannot cause a hazard.
  assign load_use = bus.ex_memread && (bus.ex_rt != REG_ZERO) &&
                    ((bus.ex_rt == bus.id_rs) || (bus.ex_rt == bus.id_rt));

  // Strobe generation
  always_comb begin
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_en      = 1'b1;
    id_ex_flush   = 1'b0;
    ex_mem_en     = 1'b1;
    mem_wb_bubble = 1'b0;
    branch_fire   = 1'b0;

    if (reset || (state_q == ERROR) || mstall) begin
      // Freeze everything up to MEM; MEM/WB takes a bubble so the stalled
      // access is not written back twice.
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      id_ex_en      = 1'b0;
      ex_mem_en     = 1'b0;
      mem_wb_bubble = 1'b1;
    end else if (bus.branch_taken) begin
      // Squash the two younger instructions; the ID one is gone, so any
      // load-use it would have raised is moot.
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      branch_fire = 1'b1;
    end else if (load_use) begin
      // Hold IF/ID and PC for one cycle and slip a bubble into EX.
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  // Sequencer next state
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    err_d   = err_q;

    case (state_q)
      RUN: begin
        if (mstall) begin
          state_d = MEM_WAIT;
          wait_d  = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (bus.mem_ready) begin
          state_d = RUN;
        end else if (wait_q == WAIT_W'(MEM_TIMEOUT)) begin
          state_d = ERROR;
          err_d   = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ERROR: begin
        state_d = ERROR;
      end
      default: begin
        // Unreachable encoding: fail safe into the locked error state.
        state_d = ERROR;
        err_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      wait_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clr_i (reset),
    .inc_i (!pc_en),
    .cnt_o (bus.stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clr_i (reset),
    .inc_i (branch_fire),
    .cnt_o (bus.flush_cnt)
  );

  assign bus.pc_en         = pc_en;
  assign bus.if_id_en      = if_id_en;
  assign bus.if_id_flush   = if_id_flush;
  assign bus.id_ex_en      = id_ex_en;
  assign bus.id_ex_flush   = id_ex_flush;
  assign bus.ex_mem_en     = ex_mem_en;
  assign bus.mem_wb_bubble = mem_wb_bubble;
  assign bus.mem_err       = err_q;

endmodule
